// File: rtl/step_seq.sv
// step_seq: turns FDC STEP/DIR into two-phase-on coil patterns for a
// four-coil unipolar stepper, holds the head busy while it settles,
// tracks the cylinder and drives the active-low TRK00 output.
// Optional build macro: HALF_STEP_EN selects 8-entry half-step drive, where
// each FDC step becomes two half-steps that each settle for SETTLE_CYCLES/2.
//
// Handshake: step_n/dir_sel are level inputs from the FDC with no ready
// path. A request is the falling edge of the synchronised step_n while
// enable=1. It is taken immediately in IDLE/HOLD, parked one-deep while
// stepping or settling, and a request that cannot be honoured raises
// step_err for one cycle.
module step_seq #(
  parameter int SETTLE_CYCLES = 36000,
  parameter int HOLD_CYCLES   = 1200000,
  parameter int MAX_TRACK     = 80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       step_n,
  input  logic       dir_sel,
  input  logic       t00_sens,
  output logic [3:0] step_drv,
  output logic       track_0,
  output logic [6:0] track_num,
  output logic       busy,
  output logic       step_err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STEP   = 2'd1,
    S_SETTLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
`ifdef HALF_STEP_EN
  localparam int PW         = 3;
  localparam int SETTLE_LEN = (SETTLE_CYCLES / 2 > 0) ? SETTLE_CYCLES / 2 : 1;
`else
  localparam int PW         = 2;
  localparam int SETTLE_LEN = SETTLE_CYCLES;
`endif
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_LEN - 1);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_CYCLES - 1);
  localparam logic [6:0]    TRACK_TOP   = 7'(MAX_TRACK - 1);

  // Coil pattern for a phase index.
  function automatic logic [3:0] coil_pattern(input logic [PW-1:0] ph);
    logic [3:0] pat;
`ifdef HALF_STEP_EN
    case (ph)
      3'd0:    pat = 4'b0001;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b0010;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0100;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1000;
      default: pat = 4'b1001;
    endcase
`else
    case (ph)
      2'd0:    pat = 4'b0011;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b1100;
      default: pat = 4'b1001;
    endcase
`endif
    return pat;
  endfunction

  // Outward (d=1) walks the table backwards, inward forwards; wraps mod size.
  function automatic logic [PW-1:0] phase_step(input logic [PW-1:0] ph, input logic d);
    return d ? ph - PW'(1) : ph + PW'(1);
  endfunction

  // Outward saturates at cylinder 0 so an unsynchronised head can be homed.
  function automatic logic [6:0] track_step(input logic [6:0] t, input logic d);
    if (d) return (t == 7'd0) ? 7'd0 : t - 7'd1;
    return t + 7'd1;
  endfunction

  function automatic logic at_top(input logic d, input logic [6:0] t);
    return !d && (t == TRACK_TOP);
  endfunction

  function automatic logic at_home(input logic d, input logic [6:0] t, input logic s);
    return d && (t == 7'd0) && s;
  endfunction

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [6:0]    track_q, track_d;
  logic [3:0]    drv_q, drv_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pend_q, pend_d;
  logic          pend_dir_q, pend_dir_d;
  logic          err_q, err_d;
  logic          t0_q;
  logic          step_s1_q, step_s2_q, step_s3_q;
  logic          dir_s1_q, dir_s2_q;
`ifdef HALF_STEP_EN
  logic          half2_q, half2_d;
  logic          dir_q, dir_d;
`endif

  logic       req, req_dir, new_req;
  logic       rest_state;
  logic [6:0] track_base;
  logic       eff_pend, eff_dir;
  logic       launch, launch_dir, launch_trk;

  assign req        = step_s3_q & ~step_s2_q;
  assign req_dir    = dir_s2_q;
  assign new_req    = req & enable;
  assign rest_state = (state_q == S_IDLE) || (state_q == S_HOLD);
  // While parked, the sensor is authoritative for cylinder 0.
  assign track_base = (rest_state && t00_sens) ? 7'd0 : track_q;
  assign eff_pend   = pend_q | new_req;
  assign eff_dir    = pend_q ? pend_dir_q : req_dir;

  // Two-flop synchronisers plus the previous-value flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_s1_q <= 1'b1;
      step_s2_q <= 1'b1;
      step_s3_q <= 1'b1;
      dir_s1_q  <= 1'b1;
      dir_s2_q  <= 1'b1;
    end else begin
      step_s1_q <= step_n;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
      dir_s1_q  <= dir_sel;
      dir_s2_q  <= dir_s1_q;
    end
  end

  // Next-state logic: one place decides whether a step launches, the shared
  // block after the case applies the phase/coil/track update.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    track_d    = track_q;
    drv_d      = drv_q;
    settle_d   = settle_q;
    hold_d     = hold_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    err_d      = 1'b0;
    launch     = 1'b0;
    launch_dir = 1'b0;
    launch_trk = 1'b1;
`ifdef HALF_STEP_EN
    half2_d    = half2_q;
    dir_d      = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        drv_d   = 4'b0000;
        track_d = track_base;
        if (new_req) begin
          if (at_top(req_dir, track_base)) begin
            err_d = 1'b1;
          end else if (!at_home(req_dir, track_base, t00_sens)) begin
            launch     = 1'b1;
            launch_dir = req_dir;
          end
        end
      end
      S_STEP: begin
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
        if (new_req) begin
          if (pend_q) err_d = 1'b1;
          else begin
            pend_d     = 1'b1;
            pend_dir_d = req_dir;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q != '0) begin
          settle_d = settle_q - SW'(1);
          if (new_req) begin
            if (pend_q) err_d = 1'b1;
            else begin
              pend_d     = 1'b1;
              pend_dir_d = req_dir;
            end
          end
        end else begin
`ifdef HALF_STEP_EN
          if (half2_q) begin
            launch     = 1'b1;
            launch_dir = dir_q;
            launch_trk = 1'b0;
            if (new_req) begin
              if (pend_q) err_d = 1'b1;
              else begin
                pend_d     = 1'b1;
                pend_dir_d = req_dir;
              end
            end
          end else
`endif
          if (!enable) begin
            state_d = S_IDLE;
            drv_d   = 4'b0000;
            pend_d  = 1'b0;
          end else if (eff_pend) begin
            pend_d = 1'b0;
            if (pend_q && new_req) err_d = 1'b1;
            if (at_top(eff_dir, track_q)) begin
              err_d   = 1'b1;
              state_d = S_HOLD;
              hold_d  = HOLD_LOAD;
            end else if (at_home(eff_dir, track_q, t00_sens)) begin
              state_d = S_HOLD;
              hold_d  = HOLD_LOAD;
            end else begin
              launch     = 1'b1;
              launch_dir = eff_dir;
            end
          end else begin
            state_d = S_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      S_HOLD: begin
        track_d = track_base;
        if (!enable) begin
          state_d = S_IDLE;
          drv_d   = 4'b0000;
        end else if (new_req && !at_top(req_dir, track_base) &&
                     !at_home(req_dir, track_base, t00_sens)) begin
          launch     = 1'b1;
          launch_dir = req_dir;
        end else begin
          if (new_req && at_top(req_dir, track_base)) err_d = 1'b1;
          if (hold_q == '0) begin
            state_d = S_IDLE;
            drv_d   = 4'b0000;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      state_d = S_STEP;
      phase_d = phase_step(phase_q, launch_dir);
      drv_d   = coil_pattern(phase_d);
      if (launch_trk) track_d = track_step(track_base, launch_dir);
`ifdef HALF_STEP_EN
      half2_d = launch_trk;
      dir_d   = launch_dir;
`endif
    end
  end

  // Sequencer state; async reset aborts any step in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      track_q    <= 7'd0;
      drv_q      <= 4'b0000;
      settle_q   <= '0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      pend_dir_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef HALF_STEP_EN
      half2_q    <= 1'b0;
      dir_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      track_q    <= track_d;
      drv_q      <= drv_d;
      settle_q   <= settle_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
      err_q      <= err_d;
`ifdef HALF_STEP_EN
      half2_q    <= half2_d;
      dir_q      <= dir_d;
`endif
    end
  end

  // Registered TRK00: low only when sensor and counter agree on cylinder 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) t0_q <= 1'b1;
    else      t0_q <= ~(t00_sens & (track_q == 7'd0));
  end

  assign step_drv  = drv_q;
  assign track_num = track_q;
  assign busy      = (state_q == S_STEP) || (state_q == S_SETTLE);
  assign step_err  = err_q;
  assign track_0   = t0_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_step_seq.sv
// Directed bench for step_seq with short settle/hold times.
module tb_step_seq;
  localparam int SETTLE = 8;
  localparam int HOLD   = 20;
  localparam int MAXT   = 6;

  logic       clk = 1'b0;
  logic       rst, enable, step_n, dir_sel, t00_sens;
  logic [3:0] step_drv;
  logic       track_0;
  logic [6:0] track_num;
  logic       busy, step_err;
  logic [1:0] state_dbg;

  int n_tests  = 0;
  int n_fail   = 0;
  int err_seen = 0;
  int bcnt;
  int trk;
  logic [3:0] exp_q[$];
  logic [3:0] exp_pat;

  step_seq #(.SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD), .MAX_TRACK(MAXT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .step_n(step_n), .dir_sel(dir_sel),
    .t00_sens(t00_sens), .step_drv(step_drv), .track_0(track_0),
    .track_num(track_num), .busy(busy), .step_err(step_err), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, noting any step_err pulse.
  task automatic tick();
    @(negedge clk);
    if (step_err === 1'b1) err_seen++;
  endtask

  task automatic pulse(input logic d, input int low_n);
    dir_sel = d;
    step_n  = 1'b0;
    repeat (low_n) tick();
    step_n  = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 60) begin
      tick();
      k++;
    end
    check(tag, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b1; step_n = 1'b1; dir_sel = 1'b0; t00_sens = 1'b0;
    tick(); tick();
    check("rst_drv", 32'(step_drv), 0);
    check("rst_track", 32'(track_num), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(step_err), 0);
    check("rst_t0", 32'(track_0), 1);
    rst = 1'b1;
    tick();

    // One inward step: coils change on the 3rd edge, busy 1+SETTLE cycles.
    step_n = 1'b0; dir_sel = 1'b0;
    tick(); tick();
    check("t1_drv_before", 32'(step_drv), 0);
    tick();
    check("t1_drv", 32'(step_drv), 4'b0110);
    check("t1_track", 32'(track_num), 1);
    check("t1_busy", 32'(busy), 1);
    bcnt = 1;
    tick();
    step_n = 1'b1;
    if (busy === 1'b1) bcnt++;
    while (busy === 1'b1 && bcnt < 30) begin
      tick();
      if (busy === 1'b1) bcnt++;
    end
    check("t1_busy_len", 32'(bcnt), 9);
    check("t1_hold_state", 32'(state_dbg), 3);
    check("t1_hold_drv", 32'(step_drv), 4'b0110);

    // 4 inward then 4 outward from phase 0.
    rst = 1'b0; tick(); rst = 1'b1; tick();
    exp_q = '{4'b0110, 4'b1100, 4'b1001, 4'b0011, 4'b1001, 4'b1100, 4'b0110, 4'b0011};
    trk = 0;
    for (int i = 0; i < 8; i++) begin
      pulse(i >= 4, 4);
      trk = (i >= 4) ? trk - 1 : trk + 1;
      exp_pat = exp_q.pop_front();
      check($sformatf("t2_drv%0d", i), 32'(step_drv), 32'(exp_pat));
      check($sformatf("t2_track%0d", i), 32'(track_num), trk);
      wait_idle($sformatf("t2_idle%0d", i));
    end
    check("t2_home", 32'(track_num), 0);

    // Two requests during settle: one pends, the next is dropped.
    err_seen = 0;
    pulse(1'b0, 4);
    check("t3_first_drv", 32'(step_drv), 4'b0110);
    tick();
    pulse(1'b0, 2);
    tick();
    pulse(1'b0, 2);
    wait_idle("t3_idle");
    check("t3_err_pulses", 32'(err_seen), 1);
    check("t3_track", 32'(track_num), 2);
    check("t3_drv", 32'(step_drv), 4'b1100);

    // Sensor at track 0: resync and outward request ignored.
    t00_sens = 1'b1;
    tick(); tick();
    check("t4_resync", 32'(track_num), 0);
    check("t4_trk00", 32'(track_0), 0);
    err_seen = 0;
    bcnt = 0;
    pulse(1'b1, 4);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0) bcnt++;
    end
    check("t4_no_busy", 32'(bcnt), 0);
    check("t4_drv_kept", 32'(step_drv), 4'b1100);
    check("t4_no_err", 32'(err_seen), 0);
    check("t4_state", 32'(state_dbg), 3);

    // Sensor clear at track 0: outward executes, count saturates.
    t00_sens = 1'b0;
    tick();
    check("t4_trk00_off", 32'(track_0), 1);
    pulse(1'b1, 4);
    check("t4_sat_drv", 32'(step_drv), 4'b0110);
    check("t4_sat_track", 32'(track_num), 0);
    wait_idle("t4_idle");

    // Hold timeout de-energises exactly HOLD cycles after settle ends.
    repeat (19) tick();
    check("t5_hold_19", 32'(step_drv), 4'b0110);
    tick();
    check("t5_hold_20", 32'(step_drv), 0);
    check("t5_idle", 32'(state_dbg), 0);
    pulse(1'b0, 4);
    check("t5_resume_drv", 32'(step_drv), 4'b1100);
    check("t5_resume_track", 32'(track_num), 1);
    wait_idle("t5_idle2");

    // enable low: HOLD drops to IDLE and requests are ignored.
    enable = 1'b0;
    tick();
    check("t6_dis_drv", 32'(step_drv), 0);
    err_seen = 0;
    pulse(1'b0, 4);
    tick(); tick();
    check("t6_ign_drv", 32'(step_drv), 0);
    check("t6_ign_track", 32'(track_num), 1);
    check("t6_ign_busy", 32'(busy), 0);
    check("t6_ign_err", 32'(err_seen), 0);
    enable = 1'b1;
    tick();

    // enable falls during settle with a request pending: pending discarded.
    pulse(1'b0, 4);
    check("t7_drv", 32'(step_drv), 4'b1001);
    tick();
    pulse(1'b0, 2);
    tick();
    enable = 1'b0;
    wait_idle("t7_idle");
    tick(); tick();
    check("t7_drv_off", 32'(step_drv), 0);
    check("t7_track", 32'(track_num), 2);
    check("t7_state", 32'(state_dbg), 0);
    enable = 1'b1;
    tick();

    // Inward at the last cylinder is dropped with an error.
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 4);
      wait_idle($sformatf("t8_idle%0d", i));
    end
    check("t8_track_top", 32'(track_num), MAXT - 1);
    err_seen = 0;
    pulse(1'b0, 4);
    tick(); tick();
    check("t8_top_err", 32'(err_seen), 1);
    check("t8_top_track", 32'(track_num), MAXT - 1);
    check("t8_top_drv", 32'(step_drv), 4'b1100);
    check("t8_top_busy", 32'(busy), 0);

    // Asynchronous reset in the middle of settle.
    pulse(1'b1, 4);
    check("t9_drv", 32'(step_drv), 4'b0110);
    check("t9_busy", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("t9_rst_drv", 32'(step_drv), 0);
    check("t9_rst_track", 32'(track_num), 0);
    check("t9_rst_busy", 32'(busy), 0);
    check("t9_rst_err", 32'(step_err), 0);
    check("t9_rst_t0", 32'(track_0), 1);
    check("t9_rst_state", 32'(state_dbg), 0);
    tick();
    rst = 1'b1;
    tick();
    pulse(1'b0, 4);
    check("t9_after_drv", 32'(step_drv), 4'b0110);
    check("t9_after_track", 32'(track_num), 1);
    wait_idle("t9_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_seq.md
Name: step_seq

Overview:
- Stepper-motor phase sequencer sitting directly downstream of the FDC step/dir inputs and upstream of the ULN2003 coil drivers.
- Converts FDC STEP pulses and DIR level into 4-coil two-phase-on patterns.
- Enforces head settle time, tracks the current cylinder and generates the track-0 output.
- De-energises the coils after an idle timeout.

Parameters:
- SETTLE_CYCLES, 36000, clocks the head is held busy after each coil change (3 ms at 12 MHz).
- HOLD_CYCLES, 1200000, idle clocks after the last step before coils are de-energised (100 ms at 12 MHz).
- MAX_TRACK, 80, number of cylinders; valid track_num range is 0..MAX_TRACK-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  drive selected and motor on; steps are accepted only when high
- step_n  in  1  FDC STEP, active-low, asynchronous to clk
- dir_sel  in  1  FDC DIR, asynchronous; 1 = outward (toward track 0), 0 = inward
- t00_sens  in  1  track-0 sensor, already buffered; 1 = head at track 0
- step_drv  out  4  coil drive, 1 = coil energised
- track_0  out  1  FDC TRK00, active-low, registered
- track_num  out  7  current cylinder
- busy  out  1  step in progress or settling
- step_err  out  1  one-cycle pulse when a step is dropped

Behaviour:
- Reset (rst=0, asynchronous):
  - step_drv=0000, phase=0, track_num=0, busy=0, step_err=0, track_0=1.
  - Synchroniser flops reset to 1; pending flag cleared; state=IDLE.
  - A mid-step reset aborts the step immediately.
- Input synchronisation:
  - step_n and dir_sel each pass through 2 flops.
  - A request is the falling edge of synchronised step_n (registered previous value=1, current=0).
  - dir is sampled from the synchronised dir_sel in the same cycle as the edge.
- Latency: step_drv updates on the 3rd rising clk edge after step_n is first sampled low.
- Coil patterns, indexed by phase 0..3: 0011, 0110, 1100, 1001.
  - Inward: phase+1 mod 4, track_num+1.
  - Outward: phase-1 mod 4, track_num-1.
- States:
  - IDLE: coils 0000, busy=0. On a request with enable=1, go to STEP.
  - STEP (1 cycle): drive step_drv = new phase pattern, update track_num, busy=1, load settle counter, go to SETTLE.
  - SETTLE: busy=1, count SETTLE_CYCLES.
    - At expiry, if the pending flag is set, clear it and go to STEP using the stored dir.
    - Otherwise go to HOLD and load the hold counter.
  - HOLD: coils stay energised, busy=0.
    - A request goes to STEP.
    - When HOLD_CYCLES expire, or enable=0, go to IDLE (coils 0000, phase retained).
- Boundary cases:
  - Request during SETTLE: stored as a one-deep pending request with its dir. A further request while pending is dropped and step_err pulses.
  - Request with enable=0: ignored silently.
  - enable falling during SETTLE: settle completes, pending is discarded, then go to IDLE.
  - Outward request with track_num=0 and t00_sens=1: no coil change, no settle, no error.
  - Inward request with track_num=MAX_TRACK-1: dropped, step_err pulses.
  - Outward request with track_num=0 and t00_sens=0: executed; track_num stays 0 (saturates).
  - Resync: in IDLE or HOLD with t00_sens=1, track_num is forced to 0.
  - track_0 is registered as ~(t00_sens & track_num==0).
  - All counters are sized to hold their parameter; no wrap beyond terminal count.

Optional Feature:
- Macro: HALF_STEP_EN.
- With the macro defined:
  - 8-entry half-step table: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
  - Each FDC step performs two half-steps, each followed by SETTLE_CYCLES/2.
  - track_num changes on the first half-step.
  - busy stays high across both half-steps.
- Without the macro: 4-phase full-step behaviour exactly as above.

Test Plan:
- Reset, then one inward step (step_n low 4 cycles, dir_sel=0, enable=1, SETTLE_CYCLES=8) -> step_drv 0000→0110 on the 3rd edge; track_num=1; busy high 9 cycles.
- 4 inward steps then 4 outward steps -> patterns 0110, 1100, 1001, 0011, then 1001, 1100, 0110, 0011; track_num returns to 0.
- Two further steps issued during SETTLE -> first executes after settle, second gives step_err=1 for exactly 1 cycle; track_num advances by 2 total.
- t00_sens=1, track_num=0, outward step -> step_drv unchanged, busy stays 0, track_0=0.
- Idle with HOLD_CYCLES=20 -> step_drv=0000 exactly 20 cycles after SETTLE ends; next step resumes from the retained phase.
- Assert rst mid-SETTLE -> all outputs at reset values immediately, without waiting for a clock.
